// File: rtl/lab3_serial_pattern_tx.sv
// Purpose  : serial pattern source; takes a WIDTH-bit word over valid/ready and shifts it out MSB-first on x.
// Latency  : first bit on x one cycle after the accept edge; one frame per WIDTH+2 cycles (WIDTH+3 with parity).
// Backpres.: in_ready is high only in IDLE, so a word is held off for the whole frame plus the DONE cycle.
//
// Optional feature: define PARITY_EN to append an even-parity bit after the last data bit.
//
// Ports:
//   clock     - rising-edge clock
//   reset     - asynchronous active-low reset
//   in_data   - word to transmit, sampled on the accept edge
//   in_valid  - in_data is valid
//   in_ready  - block can accept a word (IDLE and out of reset)
//   abort     - synchronous abort of the frame in progress
//   x         - serial data bit (registered)
//   x_valid   - x carries a frame bit this cycle (registered)
//   busy      - frame in progress (SHIFT or PARITY)
//   done      - one-cycle pulse after the last bit of a completed frame
//   frame_cnt - completed-frame counter, wraps
module lab3_serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    // Counter must hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef PARITY_EN
        PARITY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               x_q, x_d;
    logic               xv_q, xv_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   fcnt_q;
    logic               frame_inc;
`ifdef PARITY_EN
    logic               par_q, par_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            sreg_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            if (frame_inc)
                fcnt_q <= fcnt_q + CNT_W'(1);
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        xv_d      = xv_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        frame_inc = 1'b0;
`ifdef PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here: accept wins.
                if (in_valid) begin
                    x_d     = in_data[WIDTH-1];
                    xv_d    = 1'b1;
                    sreg_d  = in_data << 1;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
`ifdef PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (abort) begin
                    // Abort beats the last-bit transition, so no done and no count.
                    x_d     = 1'b0;
                    xv_d    = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q < LAST) begin
                    x_d    = sreg_q[WIDTH-1];
                    sreg_d = sreg_q << 1;
                    cnt_d  = cnt_q + CW'(1);
                end else begin
`ifdef PARITY_EN
                    x_d     = par_q;
                    xv_d    = 1'b1;
                    state_d = PARITY;
`else
                    x_d     = 1'b0;
                    xv_d    = 1'b0;
                    state_d = DONE;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                x_d     = 1'b0;
                xv_d    = 1'b0;
                state_d = abort ? IDLE : DONE;
            end
`endif
            DONE: begin
                frame_inc = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                x_d     = 1'b0;
                xv_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = reset && (state_q == IDLE);
    assign done      = (state_q == DONE);
`ifdef PARITY_EN
    assign busy      = (state_q == SHIFT) || (state_q == PARITY);
`else
    assign busy      = (state_q == SHIFT);
`endif
    assign x         = x_q;
    assign x_valid   = xv_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_lab3_serial_pattern_tx.sv
module tb_lab3_serial_pattern_tx;

    logic       clock = 1'b1;
    logic       reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       abort = 1'b0;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt = 8'd0;

    lab3_serial_pattern_tx #(.WIDTH(8), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .x(x), .x_valid(x_valid),
        .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;   // posedges at 10, 20, ...

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, x, x_valid, busy, done, frame_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b x=%b xv=%b busy=%b done=%b cnt=%0d, want all 0",
                     in_ready, x, x_valid, busy, done, frame_cnt);
        end
        #4 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (x !== 1'b0 || x_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'd0) begin
                errors++;
                $display("FAIL idle_cycle%0d: x=%b xv=%b ready=%b cnt=%0d, want 0 0 1 0",
                         i, x, x_valid, in_ready, frame_cnt);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        d = 8'b01110100;
        in_data = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'hFF;   // must not disturb the frame in flight
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x !== d[7-i] || x_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_bit%0d: x=%b xv=%b busy=%b ready=%b, want x=%b xv=1 busy=1 ready=0",
                         i + 1, x, x_valid, busy, in_ready, d[7-i]);
            end
            step();
        end
`ifdef PARITY_EN
        checks++;
        if (x !== 1'b0 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_parity: x=%b xv=%b, want 0 1", x, x_valid);
        end
        step();
`endif
        checks++;
        if (done !== 1'b1 || x_valid !== 1'b0 || x !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b xv=%b x=%b ready=%b busy=%b, want 1 0 0 0 0",
                     done, x_valid, x, in_ready, busy);
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (done !== 1'b0 || frame_cnt !== exp_cnt || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_after: done=%b cnt=%0d ready=%b, want 0 %0d 1",
                     done, frame_cnt, in_ready, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [2];
        d[0] = 8'hA5; d[1] = 8'h3C;
        in_data = d[0]; in_valid = 1'b1;
        step();
        in_data = d[1];
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (x !== d[f][7-i] || x_valid !== 1'b1 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_f%0d_bit%0d: x=%b xv=%b ready=%b, want %b 1 0",
                             f, i + 1, x, x_valid, in_ready, d[f][7-i]);
                end
                step();
            end
`ifdef PARITY_EN
            checks++;
            if (x !== ^d[f] || x_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_f%0d_parity: x=%b xv=%b, want %b 1", f, x, x_valid, ^d[f]);
            end
            step();
`endif
            checks++;
            if (done !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_f%0d_done: done=%b ready=%b, want 1 0", f, done, in_ready);
            end
            step();
            exp_cnt = exp_cnt + 8'd1;
            // Idle cycle: the second accept lands on the edge closing this cycle.
            checks++;
            if (in_ready !== 1'b1 || x_valid !== 1'b0 || frame_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL b2b_f%0d_idle: ready=%b xv=%b cnt=%0d, want 1 0 %0d",
                         f, in_ready, x_valid, frame_cnt, exp_cnt);
            end
            if (f == 1) in_valid = 1'b0;
            if (f == 0) step();
        end
    endtask

    task automatic test_abort();
        // abort mid-frame on bit 4 of 8'hFF
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (x !== 1'b1 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_bit4: x=%b xv=%b, want 1 1", x, x_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (x_valid !== 1'b0 || x !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_next: xv=%b x=%b done=%b busy=%b ready=%b, want 0 0 0 0 1",
                     x_valid, x, done, busy, in_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL abort_count: done=%b cnt=%0d, want 0 %0d", done, frame_cnt, exp_cnt);
        end
        // abort together with in_valid in IDLE: accept wins; then abort on the last bit
        in_data = 8'hC3; in_valid = 1'b1; abort = 1'b1;
        step();
        in_valid = 1'b0; abort = 1'b0;
        checks++;
        if (x !== 1'b1 || x_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_accept: x=%b xv=%b busy=%b, want 1 1 1", x, x_valid, busy);
        end
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (x !== 1'b1 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_lastbit_shown: x=%b xv=%b, want 1 1", x, x_valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (x_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_lastbit_next: xv=%b done=%b ready=%b, want 0 0 1", x_valid, done, in_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL abort_lastbit_count: done=%b cnt=%0d, want 0 %0d", done, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        in_data = 8'hB7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();          // now showing bit 3
        #2 reset = 1'b0;         // mid-cycle, away from any edge
        #1;
        exp_cnt = 8'd0;
        checks++;
        if (x_valid !== 1'b0 || x !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: xv=%b x=%b busy=%b ready=%b cnt=%0d, want all 0",
                     x_valid, x, busy, in_ready, frame_cnt);
        end
        #2 reset = 1'b1;         // released just after the negedge
        d = 8'h81;
        in_data = d; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x !== d[7-i] || x_valid !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_bit%0d: x=%b xv=%b, want %b 1", i + 1, x, x_valid, d[7-i]);
            end
            step();
        end
`ifdef PARITY_EN
        step();
`endif
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: done=%b, want 1", done);
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL post_reset_count: cnt=%0d, want %0d", frame_cnt, exp_cnt);
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        in_data = 8'h01; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (x !== 1'b1 || x_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL parity_01: x=%b xv=%b busy=%b, want 1 1 1", x, x_valid, busy);
        end
        step();
        checks++;
        if (done !== 1'b1 || x_valid !== 1'b0) begin
            errors++;
            $display("FAIL parity_01_done: done=%b xv=%b, want 1 0", done, x_valid);
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 ns");
        $fatal(1);
    end

endmodule

// File: doc/lab3_serial_pattern_tx.md
Name: lab3_serial_pattern_tx

Overview:
- Serial bit-stream transmitter: accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on a single-bit line x, one bit per clock.
- Drives the x input of the Lab3 Mealy sequence detectors, replacing hand-timed testbench stimulus with a synthesizable pattern source.
- Adds frame framing (x_valid, done), abort, and a completed-frame counter.

Parameters:
- WIDTH, 8, bits per frame; legal range 1..32.
- CNT_W, 8, width of frame_cnt.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit; sampled on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- abort  input  1  synchronous abort of the frame in progress.
- x  output  1  serial data bit, registered.
- x_valid  output  1  x carries a frame bit this cycle, registered.
- busy  output  1  frame in progress (SHIFT or PARITY state).
- done  output  1  one-cycle pulse after the last bit of a completed frame.
- frame_cnt  output  CNT_W  count of completed frames.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; x=0, x_valid=0, busy=0, done=0, frame_cnt=0, shift register=0, bit counter=0.
  - in_ready is forced to 0 while reset=0.
  - Reset takes effect immediately even mid-frame; the partial frame is lost and not counted.
- States: IDLE, SHIFT, PARITY (present only with PARITY_EN), DONE.
- in_ready = 1 only in IDLE with reset=1. It is combinational from state.
- IDLE:
  - Accept occurs on a rising edge with in_valid=1 and in_ready=1.
  - On that edge: x<=in_data[WIDTH-1], x_valid<=1, shift register<=in_data shifted left by 1, bit counter<=1, state<=SHIFT.
  - The first bit is visible in the cycle immediately after the accept edge (latency 1).
- SHIFT, each edge:
  - If bit counter < WIDTH: x<=next MSB of the shift register, counter++.
  - If counter == WIDTH: the last bit has been shown for one cycle. Go to PARITY if enabled, otherwise to DONE with x<=0, x_valid<=0.
- DONE (one cycle):
  - done=1, x_valid=0, x=0, in_ready=0.
  - frame_cnt increments on the edge leaving DONE, wrapping from 2^CNT_W-1 to 0.
  - Next state is IDLE.
- busy=1 exactly in the cycles x_valid=1.
- Throughput: one frame per WIDTH+2 cycles (WIDTH+3 with parity) under continuous in_valid.
- abort:
  - Sampled in SHIFT or PARITY. Next edge: state<=IDLE, x<=0, x_valid<=0.
  - No done pulse and no frame_cnt increment.
  - Ignored in IDLE and DONE, including when abort=1 and in_valid=1 together in IDLE; the accept wins.
  - abort asserted on the same edge as the last bit: abort wins, and the frame is not counted.
- in_data changes after the accept edge have no effect on the frame in flight.
- WIDTH=1: a single bit is shown for one cycle, then DONE.

Optional Feature:
- Macro PARITY_EN.
  - When defined: after the last data bit, state PARITY presents x = XOR of all WIDTH data bits (even parity), x_valid=1, for one cycle, then DONE. Frame length on the line is WIDTH+1.
  - abort is honoured in PARITY.
  - When undefined: the PARITY state and its logic are absent; SHIFT goes directly to DONE.

Test Plan:
- Reset then idle: hold reset=0 for 5ns, release, in_valid=0 for 10 cycles -> x=0, x_valid=0, in_ready=1, frame_cnt=0 throughout.
- Single frame, WIDTH=8, in_data=8'b01110100:
  - x over cycles 1..8 after accept = 0,1,1,1,0,1,0,0 with x_valid=1.
  - done=1 at cycle 9; frame_cnt=1 after it.
  - Feeding x into the Lab3 Mealy detector gives the same z trace as the hand-timed stimulus.
- Back-to-back, in_valid held high with 8'hA5 then 8'h3C:
  - Second accept occurs exactly 10 cycles after the first; bits 10100101 then 00111100.
  - frame_cnt=2.
- Abort: assert abort during the 4th bit of 8'hFF -> x_valid=0 on the next cycle, no done, frame_cnt unchanged, in_ready=1 one cycle later.
- Async reset mid-frame: drop reset during bit 3 -> outputs clear immediately, not on an edge. After release, a new frame of 8'h81 transmits correctly.
- PARITY_EN defined, in_data=8'b01110100 (four ones) -> parity bit 0 at cycle 9, done at cycle 10. With in_data=8'h01 -> parity bit 1.
